// File: rtl/btn_code_lock.sv
// btn_code_lock: button code lock that sits after the four-button edge detector.
// Each qualified press (ce=1 with a st* pulse) is one 2-bit digit; a CODE_LEN
// digit entry is compared against CODE. The lock then opens, reports an error,
// or locks out after MAX_FAILS consecutive wrong entries. All timing is in ce
// ticks through one shared timer.
// There is no valid/ready handshake: a press is a single-cycle event and is
// consumed in the cycle it is seen, with no back-pressure toward the buttons.
// dbg_state exposes the FSM state so checkers can bind to it.
module btn_code_lock #(
   parameter int CODE_LEN = 4,
   parameter logic [2*CODE_LEN-1:0] CODE = 8'b11_10_01_00,
   parameter int TIMEOUT = 250,
   parameter int OPEN_TICKS = 500,
   parameter int MAX_FAILS = 3,
   parameter int LOCKOUT_TICKS = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ce,
   input  logic       st0,
   input  logic       st1,
   input  logic       st2,
   input  logic       st3,
   output logic       unlock,
   output logic       err,
   output logic       lockout,
   output logic [3:0] progress,
   output logic [1:0] dbg_state
);

   // Reject illegal code lengths while the design is elaborated.
   if (CODE_LEN < 2 || CODE_LEN > 8) begin : g_bad_code_len
      $error("btn_code_lock: CODE_LEN must be in 2..8");
   end

   // Shared timer is sized for the longest of the three intervals.
   localparam int TMAX_A = (TIMEOUT > OPEN_TICKS) ? TIMEOUT : OPEN_TICKS;
   localparam int TMAX   = (TMAX_A > LOCKOUT_TICKS) ? TMAX_A : LOCKOUT_TICKS;
   localparam int TW     = $clog2(TMAX + 1);
   localparam int FW     = $clog2(MAX_FAILS + 1);

   localparam logic [TW-1:0] T_SAT     = TW'(TMAX);
   localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] T_OPEN    = TW'(OPEN_TICKS - 1);
   localparam logic [TW-1:0] T_LOCK    = TW'(LOCKOUT_TICKS - 1);
   localparam logic [FW-1:0] F_MAX     = FW'(MAX_FAILS);
   localparam logic [3:0]    P_LAST    = 4'(CODE_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTRY = 2'd1,
      S_OPEN  = 2'd2,
      S_LOCK  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [3:0]      progress_q, progress_d;
   logic            mism_q, mism_d;
   logic [FW-1:0]   fails_q, fails_d;
   logic            err_q, err_d;

   logic            press;
   logic            multi;
   logic [1:0]      digit;
   logic [2*CODE_LEN-1:0] code_sh;
   logic [1:0]      exp_digit;
   logic            bad;
   logic [TW-1:0]   timer_inc;
   logic [FW-1:0]   fails_inc;

   // Decode the press: its digit, whether it matches the expected code digit,
   // and the saturating timer / fail-count increments.
   always_comb begin
      press     = ce & (st0 | st1 | st2 | st3);
      multi     = (st0 & st1) | (st0 & st2) | (st0 & st3) |
                  (st1 & st2) | (st1 & st3) | (st2 & st3);
      digit     = st3 ? 2'd3 : (st2 ? 2'd2 : (st1 ? 2'd1 : 2'd0));
      code_sh   = CODE >> {progress_q, 1'b0};
      exp_digit = code_sh[1:0];
      bad       = multi | (digit != exp_digit);
      timer_inc = (timer_q == T_SAT) ? timer_q : timer_q + 1'b1;
      fails_inc = fails_q + 1'b1;
   end

   // Next-state and next-output logic for the lock FSM.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      progress_d = progress_q;
      mism_d     = mism_q;
      fails_d    = fails_q;
      err_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (press) begin
               state_d    = S_ENTRY;
               progress_d = 4'd1;
               mism_d     = bad;
               timer_d    = '0;
            end
         end
         S_ENTRY: begin
            // A press always wins over a simultaneous timeout.
            if (press) begin
               timer_d = '0;
               if (progress_q == P_LAST) begin
                  progress_d = 4'd0;
                  mism_d     = 1'b0;
                  if (!(mism_q | bad)) begin
                     state_d = S_OPEN;
                     fails_d = '0;
                  end else begin
                     err_d   = 1'b1;
                     fails_d = fails_inc;
                     state_d = (fails_inc == F_MAX) ? S_LOCK : S_IDLE;
                  end
               end else begin
                  progress_d = progress_q + 4'd1;
                  mism_d     = mism_q | bad;
               end
            end else if (ce) begin
               if (timer_q == T_TIMEOUT) begin
                  state_d    = S_IDLE;
                  timer_d    = '0;
                  progress_d = 4'd0;
                  mism_d     = 1'b0;
               end else begin
                  timer_d = timer_inc;
               end
            end
         end
         S_OPEN: begin
            if (ce) begin
               if (timer_q == T_OPEN) begin
                  state_d = S_IDLE;
                  timer_d = '0;
               end else begin
                  timer_d = timer_inc;
               end
            end
         end
         S_LOCK: begin
            if (ce) begin
               if (timer_q == T_LOCK) begin
                  state_d = S_IDLE;
                  timer_d = '0;
                  fails_d = '0;
               end else begin
                  timer_d = timer_inc;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
         end
      endcase
   end

   // State and status registers; reset takes effect immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         progress_q <= 4'd0;
         mism_q     <= 1'b0;
         fails_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         progress_q <= progress_d;
         mism_q     <= mism_d;
         fails_q    <= fails_d;
         err_q      <= err_d;
      end
   end

   // Status outputs decode straight from registers.
   always_comb begin
      unlock    = (state_q == S_OPEN);
      lockout   = (state_q == S_LOCK);
      err       = err_q;
      progress  = progress_q;
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_btn_code_lock.sv
// Directed bench for btn_code_lock. Expected {unlock, err, lockout, progress}
// for each clock is pushed when the stimulus for that clock is driven and
// popped once the DUT has updated. One ce tick = one clock with ce=1 followed
// by one clock with ce=0.
module tb_btn_code_lock;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ce;
   logic       st0, st1, st2, st3;
   logic       unlock, err, lockout;
   logic [3:0] progress;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;
   logic [6:0] exp_q[$];

   btn_code_lock #(
      .CODE_LEN(4),
      .CODE(8'b11_10_01_00),
      .TIMEOUT(4),
      .OPEN_TICKS(3),
      .MAX_FAILS(2),
      .LOCKOUT_TICKS(5)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ce(ce),
      .st0(st0),
      .st1(st1),
      .st2(st2),
      .st3(st3),
      .unlock(unlock),
      .err(err),
      .lockout(lockout),
      .progress(progress),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Pack expected {unlock, err, lockout, progress}.
   function automatic logic [6:0] o(input int u, input int e, input int l, input int p);
      return {u[0], e[0], l[0], p[3:0]};
   endfunction

   task automatic compare(input string tag);
      logic [6:0] obs;
      logic [6:0] exp;
      obs = {unlock, err, lockout, progress};
      exp = exp_q.pop_front();
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed u/e/l/p=%b expected %b", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic c, input logic [3:0] s, input logic [6:0] e, input string tag);
      @(negedge clk);
      ce = c;
      {st3, st2, st1, st0} = s;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      compare(tag);
   endtask

   // One ce tick: the ce cycle carries the press, the following cycle is quiet
   // and must show the same status with err already dropped.
   task automatic tick(input logic [3:0] s, input logic [6:0] e, input string tag);
      cyc(1'b1, s, e, tag);
      cyc(1'b0, 4'h0, e & 7'b1011111, {tag, "_q"});
   endtask

   task automatic correct_entry(input string tag);
      tick(4'h1, o(0,0,0,1), {tag, "_d0"});
      tick(4'h2, o(0,0,0,2), {tag, "_d1"});
      tick(4'h4, o(0,0,0,3), {tag, "_d2"});
      tick(4'h8, o(1,0,0,0), {tag, "_open"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      ce    = 1'b0;
      {st3, st2, st1, st0} = 4'h0;
      #12;
      exp_q.push_back(o(0,0,0,0));
      compare("reset");
      checks++;
      assert (dbg_state === 2'd0) else begin
         errors++;
         $error("FAIL reset_state: observed %0d expected 0", dbg_state);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Correct entry, unlock held for 3 ce ticks.
      correct_entry("ok");
      tick(4'h0, o(1,0,0,0), "open_t1");
      tick(4'h0, o(1,0,0,0), "open_t2");
      tick(4'h0, o(0,0,0,0), "open_close");

      // Wrong entry st0,st0,st2,st3: single err pulse, back to idle.
      tick(4'h1, o(0,0,0,1), "bad_d0");
      tick(4'h1, o(0,0,0,2), "bad_d1");
      tick(4'h4, o(0,0,0,3), "bad_d2");
      tick(4'h8, o(0,1,0,0), "bad_err");
      tick(4'h0, o(0,0,0,0), "bad_idle");

      // Second consecutive wrong entry enters lockout for 5 ce ticks.
      tick(4'h8, o(0,0,0,1), "bad2_d0");
      tick(4'h4, o(0,0,0,2), "bad2_d1");
      tick(4'h2, o(0,0,0,3), "bad2_d2");
      tick(4'h1, o(0,1,1,0), "lock_enter");
      for (int i = 0; i < 4; i++) tick(4'(1 << i), o(0,0,1,0), "lock_ignore");
      tick(4'h0, o(0,0,0,0), "lock_exit");

      // Correct entry after lockout; presses during OPEN are ignored.
      correct_entry("post_lock");
      tick(4'h1, o(1,0,0,0), "open_press1");
      tick(4'h2, o(1,0,0,0), "open_press2");
      tick(4'h4, o(0,0,0,0), "open_press_close");

      // Abandoned entry times out after 4 quiet ce ticks without err.
      tick(4'h1, o(0,0,0,1), "to_d0");
      tick(4'h2, o(0,0,0,2), "to_d1");
      tick(4'h0, o(0,0,0,2), "to_t1");
      tick(4'h0, o(0,0,0,2), "to_t2");
      tick(4'h0, o(0,0,0,2), "to_t3");
      tick(4'h0, o(0,0,0,0), "to_expire");
      correct_entry("post_to");
      tick(4'h0, o(1,0,0,0), "post_to_t1");
      tick(4'h0, o(1,0,0,0), "post_to_t2");
      tick(4'h0, o(0,0,0,0), "post_to_close");

      // Pulses while ce=0 are ignored, in IDLE and in ENTRY.
      cyc(1'b0, 4'h1, o(0,0,0,0), "ce0_idle");
      // Two buttons together: digit forced to mismatch.
      tick(4'h3, o(0,0,0,1), "multi_d0");
      cyc(1'b0, 4'h8, o(0,0,0,1), "ce0_entry");
      tick(4'h2, o(0,0,0,2), "multi_d1");
      tick(4'h4, o(0,0,0,3), "multi_d2");
      tick(4'h8, o(0,1,0,0), "multi_err");

      // Correct entry clears the fail count; reset while unlocked.
      correct_entry("pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.push_back(o(0,0,0,0));
      compare("rst_open");
      @(negedge clk);
      rst_n = 1'b1;

      // Reset in the middle of an entry at progress 2.
      tick(4'h1, o(0,0,0,1), "rst_e_d0");
      tick(4'h2, o(0,0,0,2), "rst_e_d1");
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.push_back(o(0,0,0,0));
      compare("rst_entry");
      @(negedge clk);
      rst_n = 1'b1;

      // After reset a fresh correct entry still opens.
      correct_entry("post_rst");

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain: observed %0d left expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
